// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand fetch stage. Holds an 8 x 8-bit register file, reads
//               rs1/rs2 for an accepted instruction (with same-cycle
//               writeback bypass) and presents the ALU operands through a
//               single-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] instr,
  input  logic       wb_en,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_op,
  output logic [2:0] alu_rd,
  output logic       illegal
);

  // Lowest opcode value flagged as illegal.
  localparam logic [2:0] c_first_illegal_op = 3'b100;

  logic [7:0] r_regs [0:7];
  logic       r_out_valid;
  logic [7:0] r_alu_in1;
  logic [7:0] r_alu_in2;
  logic [2:0] r_alu_op;
  logic [2:0] r_alu_rd;
  logic       r_illegal;

  logic [2:0] w_opcode;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic       w_accept;
  logic [7:0] w_op1;
  logic [7:0] w_op2;

  assign w_opcode = instr[8:6];
  assign w_rs1    = instr[5:3];
  assign w_rs2    = instr[2:0];

  // Single-entry output register: free when empty or draining this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Write-through bypass so an operand never misses a same-cycle writeback.
  assign w_op1 = (wb_en && (wb_addr == w_rs1)) ? wb_data : r_regs[w_rs1];
  assign w_op2 = (wb_en && (wb_addr == w_rs2)) ? wb_data : r_regs[w_rs2];

  // Register file write port, driven only by writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Output register: load on accept, clear valid on drain without refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_alu_op    <= '0;
      r_alu_rd    <= '0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_in1   <= w_op1;
      r_alu_in2   <= w_op2;
      r_alu_op    <= w_opcode;
      r_alu_rd    <= w_rs1;
      r_illegal   <= (w_opcode >= c_first_illegal_op);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_in1   = r_alu_in1;
  assign alu_in2   = r_alu_in2;
  assign alu_op    = r_alu_op;
  assign alu_rd    = r_alu_rd;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instr;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [2:0] alu_op;
  logic [2:0] alu_rd;
  logic       illegal;

  int tests = 0;
  int fails = 0;

  operand_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_rd    (alu_rd),
    .illegal   (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] b2b_instr [0:3];
  logic [7:0] b2b_in1   [0:3];
  logic [7:0] b2b_in2   [0:3];
  logic [2:0] b2b_op    [0:3];

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", {8'd0, out_valid}, 9'd0);
    check("rst_in_ready",  {8'd0, in_ready},  9'd1);
    check("rst_alu_in1",   {1'b0, alu_in1},   9'd0);
    step(); step();
    reset = 1'b0;

    // Load R2=0x05, R3=0x03
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h05;
    step();
    wb_addr = 3'd3; wb_data = 8'h03;
    step();
    wb_en = 1'b0;

    // Basic accept: ADD r2, r3
    in_valid = 1'b1; instr = 9'b000_010_011;
    step();
    in_valid = 1'b0;
    check("basic_valid", {8'd0, out_valid}, 9'd1);
    check("basic_in1",   {1'b0, alu_in1},   9'h05);
    check("basic_in2",   {1'b0, alu_in2},   9'h03);
    check("basic_op",    {6'd0, alu_op},    9'd0);
    check("basic_rd",    {6'd0, alu_rd},    9'd2);
    check("basic_ill",   {8'd0, illegal},   9'd0);

    // Drain with no refill
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_valid", {8'd0, out_valid}, 9'd0);

    // Both operand ports bypassed from same-cycle writeback
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'hA5;
    in_valid = 1'b1; instr = 9'b011_100_100;
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    check("byp_in1", {1'b0, alu_in1}, 9'hA5);
    check("byp_in2", {1'b0, alu_in2}, 9'hA5);
    check("byp_op",  {6'd0, alu_op},  9'd3);
    check("byp_rd",  {6'd0, alu_rd},  9'd4);

    // Stall: out_ready low, new instruction pending, write to held rs1
    in_valid = 1'b1; instr = 9'b000_001_001;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h11;
    #1;
    check("stall_in_ready", {8'd0, in_ready}, 9'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_en = 1'b0;
      check("stall_valid", {8'd0, out_valid}, 9'd1);
      check("stall_in1",   {1'b0, alu_in1},   9'hA5);
      check("stall_op",    {6'd0, alu_op},    9'd3);
    end

    // Back-to-back: R2=05 R3=03 R4=11, others 0; held entry drains as first accepts
    b2b_instr[0] = 9'b001_010_011; b2b_in1[0] = 8'h05; b2b_in2[0] = 8'h03; b2b_op[0] = 3'd1;
    b2b_instr[1] = 9'b010_100_010; b2b_in1[1] = 8'h11; b2b_in2[1] = 8'h05; b2b_op[1] = 3'd2;
    b2b_instr[2] = 9'b011_011_100; b2b_in1[2] = 8'h03; b2b_in2[2] = 8'h11; b2b_op[2] = 3'd3;
    b2b_instr[3] = 9'b000_000_010; b2b_in1[3] = 8'h00; b2b_in2[3] = 8'h05; b2b_op[3] = 3'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = b2b_instr[i];
      step();
      check("b2b_valid", {8'd0, out_valid}, 9'd1);
      check("b2b_in1",   {1'b0, alu_in1},   {1'b0, b2b_in1[i]});
      check("b2b_in2",   {1'b0, alu_in2},   {1'b0, b2b_in2[i]});
      check("b2b_op",    {6'd0, alu_op},    {6'd0, b2b_op[i]});
    end
    in_valid = 1'b0;
    step();
    check("b2b_no_dup", {8'd0, out_valid}, 9'd0);
    out_ready = 1'b0;

    // Illegal opcode passes through
    in_valid = 1'b1; instr = 9'b101_001_010;
    step();
    in_valid = 1'b0;
    check("ill_flag",  {8'd0, illegal},   9'd1);
    check("ill_op",    {6'd0, alu_op},    9'd5);
    check("ill_valid", {8'd0, out_valid}, 9'd1);
    check("ill_in2",   {1'b0, alu_in2},   9'h05);

    // Async reset mid-cycle with a held instruction and R1=0x7F
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h7F;
    step();
    wb_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid",    {8'd0, out_valid}, 9'd0);
    check("arst_in1",      {1'b0, alu_in1},   9'd0);
    check("arst_in2",      {1'b0, alu_in2},   9'd0);
    check("arst_op",       {6'd0, alu_op},    9'd0);
    check("arst_rd",       {6'd0, alu_rd},    9'd0);
    check("arst_ill",      {8'd0, illegal},   9'd0);
    check("arst_in_ready", {8'd0, in_ready},  9'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // R1 cleared by reset; first accept appears after one cycle
    in_valid = 1'b1; instr = 9'b000_001_000;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", {8'd0, out_valid}, 9'd1);
    check("post_rst_r1",    {1'b0, alu_in1},   9'h00);
    check("post_rst_rd",    {6'd0, alu_rd},    9'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; polarity and synchronicity are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  instruction word on `instr` is valid.
REQ-005 in_ready  output  1  stage accepts `instr` this cycle.
REQ-006 instr  input  9  instruction: [8:6] opcode, [5:3] rs1 (also rd), [2:0] rs2.
REQ-007 wb_en  input  1  register write enable from writeback.
REQ-008 wb_addr  input  3  register written.
REQ-009 wb_data  input  8  data written.
REQ-010 out_valid  output  1  ALU operands held on outputs are valid.
REQ-011 out_ready  input  1  downstream ALU stage consumes operands.
REQ-012 alu_in1  output  8  operand 1 = R[rs1].
REQ-013 alu_in2  output  8  operand 2 = R[rs2].
REQ-014 alu_op  output  3  opcode passed through: 000 ADD, 001 SUB, 010 AND, 011 XOR.
REQ-015 alu_rd  output  3  destination register (= rs1) for writeback.
REQ-016 illegal  output  1  the held opcode is 100-111.

Function
REQ-017 SHALL contain 8 x 8-bit registers R0-R7, all writable and all readable.
REQ-018 SHALL write R[wb_addr] <= wb_data at the rising edge whenever wb_en=1, independent of the handshake.
REQ-019 SHALL drive in_ready = !out_valid || out_ready combinationally; the output register is single-entry.
REQ-020 SHALL accept an instruction on a rising edge when in_valid && in_ready, and load all output fields plus illegal at that edge (latency 1 cycle).
REQ-021 SHALL sample operands at acceptance; when wb_en=1 and wb_addr equals rs1 or rs2 in the acceptance cycle, the matching operand SHALL take wb_data (write-through bypass, both ports independently).
REQ-022 SHALL set out_valid=1 on acceptance, keep it 1 and hold all outputs stable while out_ready=0, and clear it on out_valid && out_ready with no new acceptance.
REQ-023 On simultaneous consume and accept in one cycle, SHALL keep out_valid=1 and replace the outputs with the new instruction, giving zero-bubble throughput of 1 per cycle.
REQ-024 Held operands SHALL NOT change when a later writeback targets their register; forwarding happens only at acceptance.
REQ-025 Opcodes 100-111 SHALL pass through unchanged with illegal=1; they are otherwise handled as normal instructions, with no stall or drop.
REQ-026 in_valid=0 SHALL leave all state except the register file unchanged.

Reset
REQ-027 reset=1 SHALL immediately clear R0-R7, out_valid, alu_in1, alu_in2, alu_op, alu_rd and illegal to 0, regardless of clk.
REQ-028 While reset=1, in_ready SHALL be 1 (out_valid=0), and no acceptance or register write SHALL occur.
REQ-029 Reset asserted while out_valid=1 and out_ready=0 SHALL discard the held instruction; after release, the first accepted instruction appears after 1 cycle.

Verification
REQ-030 Write R2=0x05 and R3=0x03, then accept instr=000_010_011 -> next cycle out_valid=1, alu_in1=0x05, alu_in2=0x03, alu_op=000, alu_rd=2, illegal=0.
REQ-031 Same cycle: wb_en=1, wb_addr=4, wb_data=0xA5, and accept instr=011_100_100 -> alu_in1=alu_in2=0xA5 (both ports bypassed).
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, and a write to the held rs1 does not alter alu_in1.
REQ-033 Hold in_valid=1 and out_ready=1 continuously with 4 back-to-back instructions -> 4 consecutive out_valid cycles, with no bubble and no duplicate.
REQ-034 Accept instr=101_001_010 -> illegal=1 and alu_op=101.
REQ-035 Assert reset asynchronously mid-cycle with out_valid=1 and R1=0x7F -> out_valid=0 and all outputs 0 immediately; after release, reading R1 yields 0x00.
